// File: rtl/pulse_stretch.sv
// Stretches one-cycle strobes into HIGH_CYCLES-long level pulses separated by GAP_CYCLES low gaps.
// Optional retrigger (define PULSE_STRETCH_RETRIGGER_EN): a strobe during HIGH restarts the high time.
module pulse_stretch #(
    parameter int HIGH_CYCLES = 20000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int CNT_W       = 26,
    parameter int PEND_W      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PULSE,
    output logic              LEVEL,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic               level_q;

    logic               pend_nz;
    logic               start;
    logic               take_start;
    logic               queue_pulse;

    assign pend_nz = (pend_q != '0);
    assign start   = PULSE | pend_nz;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        take_start  = 1'b0;
        queue_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HIGH;
                    cnt_d      = '0;
                    take_start = 1'b1;
                end
            end
            S_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                if (PULSE) begin
                    cnt_d = '0;
                end else
`else
                queue_pulse = PULSE;
`endif
                if (cnt_q == HIGH_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (start) begin
                        state_d    = S_HIGH;
                        take_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    queue_pulse = PULSE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A start with a fresh strobe and a queued event nets to no change.
        if (take_start) begin
            if (pend_nz && !PULSE) begin
                pend_d = pend_q - 1'b1;
            end
        end else if (queue_pulse) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= (state_d == S_HIGH);
        end
    end

    assign LEVEL    = level_q;
    assign BUSY     = (state_q != S_IDLE);
    assign PENDING  = pend_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: a timeline model (period start/end times plus a
// pending count) is checked every cycle, and literal sequences pin the model itself.
module tb_pulse_stretch;

    localparam int H      = 4;
    localparam int G      = 2;
    localparam int PEND_W = 2;
    localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              PULSE = 1'b0;
    logic              LEVEL;
    logic              BUSY;
    logic [PEND_W-1:0] PENDING;
    logic              OVERFLOW;

    pulse_stretch #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .CNT_W      (3),
        .PEND_W     (PEND_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PULSE   (PULSE),
        .LEVEL   (LEVEL),
        .BUSY    (BUSY),
        .PENDING (PENDING),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: current period is high in [hs, he) and busy in [hs, he+G).
    int cyc    = 0;
    int hs     = -1000;
    int he     = -1000;
    int m_pend = 0;
    int m_ovf  = 0;

    int          hi_cnt = 0;
    logic [15:0] lv_seq = '0;
    logic [15:0] bs_seq = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic r = 1'b0);
        bit in_high, busy, can_start;
        PULSE = p;
        RST   = r;
        @(posedge CLK);
        if (r) begin
            hs = -1000; he = -1000; m_pend = 0; m_ovf = 0;
        end else begin
            in_high   = (hs <= cyc) && (cyc < he);
            busy      = (hs <= cyc) && (cyc < he + G);
            can_start = (cyc >= he + G - 1);
            if (can_start && (p || m_pend != 0)) begin
                hs = cyc + 1;
                he = cyc + 1 + H;
                if (m_pend != 0 && !p) m_pend--;
            end else if (RETRIG && in_high && p) begin
                he = cyc + 1 + H;
            end else if (busy && p) begin
                if (m_pend < PMAX) m_pend++;
                else m_ovf = 1;
            end
        end
        cyc++;
        #1;
        chk("level",    int'(LEVEL),    ((hs <= cyc) && (cyc < he)) ? 1 : 0);
        chk("busy",     int'(BUSY),     ((hs <= cyc) && (cyc < he + G)) ? 1 : 0);
        chk("pending",  int'(PENDING),  m_pend);
        chk("overflow", int'(OVERFLOW), m_ovf);
        lv_seq = {lv_seq[14:0], LEVEL};
        bs_seq = {bs_seq[14:0], BUSY};
        if (LEVEL) hi_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_busy",  int'(BUSY),  0);
        chk("rst_pend",  int'(PENDING), 0);
        chk("rst_ovf",   int'(OVERFLOW), 0);

        // 1: single strobe
        step(1'b1);
        idle(6);
        chk("s1_level_seq", int'(lv_seq[6:0]), int'(7'b1111000));
        chk("s1_busy_seq",  int'(bs_seq[6:0]), int'(7'b1111110));
        $display("[TB] scenario 1 single strobe done");

        // 2: three consecutive strobes
        step(1'b0, 1'b1);
        hi_cnt = 0;
        step(1'b1); step(1'b1); step(1'b1);
        chk("s2_pend_after3", int'(PENDING), 2);
        idle(27);
        chk("s2_high_cycles", hi_cnt, 12);
        chk("s2_idle_busy", int'(BUSY), 0);
        $display("[TB] scenario 2 queued strobes done");

        // 3: saturation and sticky overflow
        step(1'b0, 1'b1);
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("s3_pend_sat", int'(PENDING), 3);
        chk("s3_ovf_set",  int'(OVERFLOW), 1);
        idle(34);
        chk("s3_high_cycles", hi_cnt, 16);
        chk("s3_ovf_sticky",  int'(OVERFLOW), 1);
        chk("s3_idle_busy",   int'(BUSY), 0);
        $display("[TB] scenario 3 saturation done");

        // 4: strobe on final gap cycle
        step(1'b0, 1'b1);
        step(1'b1);
        idle(5);
        step(1'b1);
        chk("s4_level_seq", int'(lv_seq[6:0]), int'(7'b1111001));
        chk("s4_pend", int'(PENDING), 0);
        idle(10);
        $display("[TB] scenario 4 final-gap strobe done");

        // 5: reset mid-operation
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1);
        idle(3);
        chk("s5_pre_level", int'(LEVEL), 1);
        chk("s5_pre_pend",  int'(PENDING), 2);
        chk("s5_pre_ovf",   int'(OVERFLOW), 1);
        step(1'b0, 1'b1);
        chk("s5_level", int'(LEVEL), 0);
        chk("s5_busy",  int'(BUSY), 0);
        chk("s5_pend",  int'(PENDING), 0);
        chk("s5_ovf",   int'(OVERFLOW), 0);
        step(1'b1);
        idle(6);
        chk("s5_level_seq", int'(lv_seq[6:0]), int'(7'b1111000));
        chk("s5_busy_seq",  int'(bs_seq[6:0]), int'(7'b1111110));
        $display("[TB] scenario 5 mid-run reset done");

        // 6: second strobe on third high cycle
        step(1'b0, 1'b1);
        step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        idle(8);
`ifdef PULSE_STRETCH_RETRIGGER_EN
        chk("s6_level_seq", int'(lv_seq[11:0]), int'(12'b111111100000));
`else
        chk("s6_level_seq", int'(lv_seq[11:0]), int'(12'b111100111100));
`endif
        chk("s6_pend", int'(PENDING), 0);
        idle(6);
        $display("[TB] scenario 6 strobe during high done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
Converts single-cycle event strobes into human-visible, rate-limited level pulses. Each strobe produces one output high period of HIGH_CYCLES, followed by a low gap of GAP_CYCLES. Strobes that arrive while a period or gap is in progress are queued in a saturating pending counter. It is the output-side counterpart of the edge-to-strobe conditioner: that block turns a button level into a one-cycle event, and this block turns one-cycle events back into LED, buzzer or external-line levels.

Parameters:
HIGH_CYCLES, 20000000, output high duration in clock cycles; must be >= 1.
GAP_CYCLES, 1000000, minimum low time between consecutive high periods; must be >= 1.
CNT_W, 26, width of the internal duration counter; must hold max(HIGH_CYCLES, GAP_CYCLES) - 1.
PEND_W, 4, width of the pending-event counter; saturates at 2^PEND_W - 1.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
PULSE  input  1  event strobe; every cycle it is high counts as one event.
LEVEL  output  1  stretched output level.
BUSY  output  1  high whenever the state is not IDLE.
PENDING  output  PEND_W  number of queued, not-yet-started events.
OVERFLOW  output  1  sticky flag: at least one event was dropped at saturation.

Behaviour:
- Reset is one clock, one synchronous active-high reset, named CLK and RST. RST is sampled on the rising edge of CLK.
- On reset: state IDLE, LEVEL 0, BUSY 0, PENDING 0, OVERFLOW 0, counter 0.
- Reset mid-operation: all of the above take effect at the next edge, regardless of state. LEVEL drops immediately after that edge. Queued events are discarded.
- States: IDLE, HIGH, GAP. LEVEL is registered and equals (state == HIGH). BUSY equals (state != IDLE).
- Start condition: start = PULSE | (PENDING != 0). It is evaluated in IDLE, and in GAP on the final gap cycle (counter == GAP_CYCLES-1).
- On start: next state HIGH, counter cleared. LEVEL rises one cycle after the PULSE edge (latency 1).
- Pending accounting on start:
  - PENDING == 0 and PULSE: the pulse is consumed directly; PENDING stays 0.
  - PENDING != 0 and no PULSE: PENDING decrements by 1.
  - PENDING != 0 and PULSE: PENDING is unchanged (decrement and increment cancel).
- HIGH: counter increments every cycle. When counter == HIGH_CYCLES-1, go to GAP and clear the counter. LEVEL is therefore high for exactly HIGH_CYCLES cycles.
- GAP: counter increments every cycle. On the final cycle, go to HIGH if start, otherwise IDLE. Back-to-back periods are separated by exactly GAP_CYCLES low cycles.
- PULSE in HIGH or GAP (excluding the final gap cycle when start is taken):
  - If PENDING < 2^PEND_W-1: PENDING increments.
  - Otherwise: the event is dropped and OVERFLOW is set.
- OVERFLOW is cleared only by RST.
- Counter arithmetic is unsigned, CNT_W wide. Comparisons use the full width. The counter never wraps in normal operation.

Optional Feature:
Macro: PULSE_STRETCH_RETRIGGER_EN.
- Defined: a PULSE while in HIGH clears the counter, restarting the high duration, and is not queued. LEVEL therefore stays high until HIGH_CYCLES cycles after the last strobe. PULSE in GAP is still queued as normal.
- Not defined: a PULSE in HIGH is queued exactly as described in Behaviour.

Test Plan:
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2, macro off unless stated.
1. RST for 2 cycles, then a single PULSE at edge t -> LEVEL high for edges t+1..t+4. BUSY high t+1..t+6. Back in IDLE with BUSY 0 at t+7. PENDING stays 0.
2. PULSE high for 3 consecutive cycles from IDLE -> PENDING goes 1 then 2. Three LEVEL periods of 4 cycles, separated by exactly 2 low cycles. PENDING is 0 once the third period starts.
3. One PULSE from IDLE, then 5 PULSEs during HIGH -> PENDING saturates at 3 and OVERFLOW=1 after the 4th of those 5. Exactly 4 high periods total. OVERFLOW remains 1 after IDLE.
4. PULSE on the final gap cycle with PENDING 0 -> the next HIGH starts on the following edge. Low gap is exactly 2 cycles. PENDING stays 0.
5. RST asserted on HIGH cycle 2 with PENDING=2 and OVERFLOW=1 -> at the next edge LEVEL=0, BUSY=0, PENDING=0, OVERFLOW=0. A subsequent PULSE behaves as in scenario 1.
6. PULSE at t, then another on the 3rd HIGH cycle -> macro on: LEVEL high 7 consecutive cycles, PENDING 0. Macro off: 4 high, 2 low, 4 high.
